// File: rtl/process_scheduler.sv
// Round-robin time-slice scheduler: picks the next ready process, sequences
// context save/restore strobes and stalls the CPU while switching.
//
// Ports:
//   clock, reset         : rising-edge clock, async active-low reset
//   enable               : multiprocess mode active
//   instr_done           : one instruction retired this cycle
//   proc_set, proc_id    : mark slot proc_id ready
//   end_of_process       : running process finished
//   halt                 : processor halted, time slice frozen
//   cpu_stall            : freeze PC and fetch
//   save_ctx             : save running context (1-cycle strobe)
//   restore_ctx          : load current_pid context (1-cycle strobe)
//   change_rom           : switch ROM offset to current_pid (1-cycle strobe)
//   current_pid          : running or last-run process
//   ready_mask           : ready bit per slot
//   idle                 : scheduler in IDLE
module process_scheduler #(
    parameter int NPROC   = 8,
    parameter int QUANTUM = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       instr_done,
    input  logic       proc_set,
    input  logic [2:0] proc_id,
    input  logic       end_of_process,
    input  logic       halt,
    output logic       cpu_stall,
    output logic       save_ctx,
    output logic       restore_ctx,
    output logic       change_rom,
    output logic [2:0] current_pid,
    output logic [7:0] ready_mask,
    output logic       idle
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        RESTORE,
        RUN,
        SAVE
    } state_t;

    localparam logic [7:0] QM1 = 8'(QUANTUM - 1);
    localparam logic [3:0] NP  = 4'(NPROC);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [7:0] mask_nx;
    logic [2:0] pid_nx;
    logic [2:0] sel_pid;
    logic [2:0] idx;
    logic       sel_any;
    logic       to_idle, to_idle_nx;

    // Scan upward from current_pid+1 with wrap; i=8 wraps to
    // current_pid itself so it is considered last.
    always_comb begin
        sel_pid = current_pid;
        sel_any = 1'b0;
        idx     = '0;
        for (int i = 1; i <= 8; i++) begin
            idx = current_pid + 3'(i);
            if (!sel_any && ready_mask[idx]) begin
                sel_pid = idx;
                sel_any = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pid_nx     = current_pid;
        mask_nx    = ready_mask;
        to_idle_nx = to_idle;
        unique case (state)
            IDLE: begin
                if (enable && ready_mask != 8'h00)
                    state_nx = SELECT;
            end
            SELECT: begin
                if (sel_any) begin
                    state_nx = RESTORE;
                    pid_nx   = sel_pid;
                end else begin
                    state_nx = IDLE;
                end
            end
            RESTORE: begin
                cnt_nx     = '0;
                to_idle_nx = 1'b0;
                state_nx   = RUN;
            end
            RUN: begin
                if (end_of_process) begin
                    mask_nx[current_pid] = 1'b0;
                    state_nx             = SELECT;
                end else if (!enable) begin
                    to_idle_nx = 1'b1;
                    state_nx   = SAVE;
                end else if (instr_done && !halt) begin
                    if (cnt == QM1)
                        state_nx = SAVE;
                    else
                        cnt_nx = cnt + 8'd1;
                end
            end
            SAVE: begin
                state_nx   = to_idle ? IDLE : SELECT;
                to_idle_nx = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
        // Applied after the end_of_process clear so a same-slot set wins.
        if (proc_set && ({1'b0, proc_id} < NP))
            mask_nx[proc_id] = 1'b1;
    end

    // Outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            current_pid <= '0;
            ready_mask  <= '0;
            to_idle     <= 1'b0;
            idle        <= 1'b1;
            cpu_stall   <= 1'b0;
            save_ctx    <= 1'b0;
            restore_ctx <= 1'b0;
            change_rom  <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            current_pid <= pid_nx;
            ready_mask  <= mask_nx;
            to_idle     <= to_idle_nx;
            idle        <= (state_nx == IDLE);
            cpu_stall   <= (state_nx == SELECT) ||
                           (state_nx == RESTORE) ||
                           (state_nx == SAVE);
            save_ctx    <= (state_nx == SAVE);
            restore_ctx <= (state_nx == RESTORE);
            change_rom  <= (state_nx == RESTORE);
        end
    end

endmodule
